// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder and the decode stage.
// Opcodes, functs, request format encoding and field legality helpers.
package mips_isa_pkg;

   typedef enum logic [1:0] {
      FMT_R   = 2'd0,
      FMT_I   = 2'd1,
      FMT_J   = 2'd2,
      FMT_ILL = 2'd3
   } req_fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_FULL   = 2'd3
   } enc_state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_OR    = 6'h25;

   // Only sll may carry a non-zero shift amount.
   function automatic logic r_legal(input logic [5:0] funct, input logic [4:0] shamt);
      return (funct == FN_SLL) ||
             (((funct == FN_ADD) || (funct == FN_OR)) && (shamt == 5'd0));
   endfunction

   function automatic logic i_legal(input logic [5:0] opcode);
      return (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_LW) ||
             (opcode == OP_SW)   || (opcode == OP_BEQ)  || (opcode == OP_BNE);
   endfunction

   function automatic logic j_legal(input logic [5:0] opcode);
      return (opcode == OP_J) || (opcode == OP_JAL);
   endfunction

endpackage

// File: rtl/mips_field_packer.sv
// Combinational packer: assembles a 32-bit MIPS word from request fields
// and reports whether the field combination is a supported instruction.
import mips_isa_pkg::*;

module mips_field_packer (
   input  logic [1:0]  req_fmt_i,
   input  logic [5:0]  req_opcode_i,
   input  logic [5:0]  req_funct_i,
   input  logic [4:0]  req_rs_i,
   input  logic [4:0]  req_rt_i,
   input  logic [4:0]  req_rd_i,
   input  logic [4:0]  req_shamt_i,
   input  logic [15:0] req_imm_i,
   input  logic [25:0] req_target_i,
   output logic [31:0] word_o,
   output logic        legal_o
);

   // Field packing and legality per instruction format.
   always_comb begin
      word_o  = 32'h0000_0000;
      legal_o = 1'b0;
      case (req_fmt_e'(req_fmt_i))
         FMT_R: begin
            word_o  = {OP_RTYPE, req_rs_i, req_rt_i, req_rd_i, req_shamt_i, req_funct_i};
            legal_o = r_legal(req_funct_i, req_shamt_i);
         end
         FMT_I: begin
            word_o  = {req_opcode_i, req_rs_i, req_rt_i, req_imm_i};
            legal_o = i_legal(req_opcode_i);
         end
         FMT_J: begin
            word_o  = {req_opcode_i, req_target_i};
            legal_o = j_legal(req_opcode_i);
         end
         default: begin
            word_o  = 32'h0000_0000;
            legal_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mips_instr_encoder.sv
// Instruction encoder: packs field requests into MIPS words and writes them
// sequentially to instruction memory. ENCODER_CHECKSUM_EN adds an XOR checksum.
import mips_isa_pkg::*;

module mips_instr_encoder #(
   parameter int ADDR_WIDTH = 8,
   parameter int BASE_ADDR  = 0,
   parameter int MAX_WORDS  = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_fmt,
   input  logic [5:0]            req_opcode,
   input  logic [5:0]            req_funct,
   input  logic [4:0]            req_rs,
   input  logic [4:0]            req_rt,
   input  logic [4:0]            req_rd,
   input  logic [4:0]            req_shamt,
   input  logic [15:0]           req_imm,
   input  logic [25:0]           req_target,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ack,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  full,
   output logic                  err_illegal
`ifdef ENCODER_CHECKSUM_EN
   ,
   output logic [31:0]           checksum
`endif
);

   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0]   MAX_C  = (ADDR_WIDTH+1)'(MAX_WORDS);

   enc_state_e            state_q;
   logic                  req_ready_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [31:0]           mem_wdata_q;
   logic [ADDR_WIDTH:0]   word_count_q;
   logic                  full_q;
   logic                  err_illegal_q;
   logic [31:0]           checksum_q;
   logic [31:0]           packed_word_d;
   logic                  packed_legal_d;
   logic [ADDR_WIDTH:0]   word_count_d;

   mips_field_packer u_packer (
      .req_fmt_i    (req_fmt),
      .req_opcode_i (req_opcode),
      .req_funct_i  (req_funct),
      .req_rs_i     (req_rs),
      .req_rt_i     (req_rt),
      .req_rd_i     (req_rd),
      .req_shamt_i  (req_shamt),
      .req_imm_i    (req_imm),
      .req_target_i (req_target),
      .word_o       (packed_word_d),
      .legal_o      (packed_legal_d)
   );

   assign word_count_d = word_count_q + (ADDR_WIDTH+1)'(1);

   // Load FSM with address counter, write handshake and sticky flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         req_ready_q   <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= BASE_A;
         mem_wdata_q   <= 32'h0000_0000;
         word_count_q  <= '0;
         full_q        <= 1'b0;
         err_illegal_q <= 1'b0;
         checksum_q    <= 32'h0000_0000;
      end else if (start) begin
         state_q       <= ST_ACCEPT;
         req_ready_q   <= 1'b1;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= BASE_A;
         word_count_q  <= '0;
         full_q        <= 1'b0;
         err_illegal_q <= 1'b0;
         checksum_q    <= 32'h0000_0000;
      end else begin
         case (state_q)
            ST_IDLE: state_q <= ST_IDLE;
            ST_ACCEPT: begin
               if (req_valid && req_ready_q) begin
                  if (packed_legal_d) begin
                     state_q     <= ST_WRITE;
                     req_ready_q <= 1'b0;
                     mem_we_q    <= 1'b1;
                     mem_wdata_q <= packed_word_d;
                  end else begin
                     err_illegal_q <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (mem_ack) begin
                  mem_we_q     <= 1'b0;
                  mem_addr_q   <= mem_addr_q + ADDR_WIDTH'(1);
                  word_count_q <= word_count_d;
                  checksum_q   <= checksum_q ^ mem_wdata_q;
                  if (word_count_d == MAX_C) begin
                     state_q     <= ST_FULL;
                     full_q      <= 1'b1;
                     req_ready_q <= 1'b0;
                  end else begin
                     state_q     <= ST_ACCEPT;
                     req_ready_q <= 1'b1;
                  end
               end
            end
            ST_FULL: state_q <= ST_FULL;
            default: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b0;
               mem_we_q    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign word_count  = word_count_q;
   assign full        = full_q;
   assign err_illegal = err_illegal_q;
`ifdef ENCODER_CHECKSUM_EN
   assign checksum    = checksum_q;
`else
   logic unused_checksum;
   assign unused_checksum = ^checksum_q;
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized self-checking bench for mips_instr_encoder against a field-level
// reference model; also exercises the ENCODER_CHECKSUM_EN build when defined.
module tb_mips_instr_encoder;

   localparam int AW = 8;
   localparam int MW = 4;

   typedef struct {
      int fmt; int opcode; int funct; int rs; int rt; int rd;
      int shamt; int imm; int target;
   } req_t;

   logic          clk = 1'b0;
   logic          reset, start, req_valid, mem_ack;
   logic          req_ready, mem_we, full, err_illegal;
   logic [1:0]    req_fmt;
   logic [5:0]    req_opcode, req_funct;
   logic [4:0]    req_rs, req_rt, req_rd, req_shamt;
   logic [15:0]   req_imm;
   logic [25:0]   req_target;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [AW:0]   word_count;
`ifdef ENCODER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   int n_checks = 0;
   int n_errors = 0;

   int exp_count, exp_addr;
   bit exp_err, exp_full, exp_ready;
   logic [31:0] exp_chk;

   always #5 clk = ~clk;

   mips_instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .MAX_WORDS(MW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_fmt(req_fmt), .req_opcode(req_opcode), .req_funct(req_funct),
      .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
      .req_imm(req_imm), .req_target(req_target),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .word_count(word_count), .full(full), .err_illegal(err_illegal)
`ifdef ENCODER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference encoder: word from field weights, legality from the ISA tables.
   function automatic void model_enc(input req_t r, output logic [31:0] w, output bit ok);
      longint v;
      v  = 0;
      ok = 0;
      case (r.fmt)
         0: begin
            v  = longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.rd) * 2048
               + longint'(r.shamt) * 64 + longint'(r.funct);
            ok = (r.funct inside {0, 32, 37}) && (r.shamt == 0 || r.funct == 0);
         end
         1: begin
            v  = longint'(r.opcode) * 67108864 + longint'(r.rs) * 2097152
               + longint'(r.rt) * 65536 + longint'(r.imm);
            ok = r.opcode inside {8, 12, 35, 43, 4, 5};
         end
         2: begin
            v  = longint'(r.opcode) * 67108864 + longint'(r.target);
            ok = r.opcode inside {2, 3};
         end
         default: begin
            v  = 0;
            ok = 0;
         end
      endcase
      w = v[31:0];
   endfunction

   task automatic check_state(input string tag);
      check_eq({tag, "_we"},    mem_we, 0);
      check_eq({tag, "_cnt"},   word_count, exp_count);
      check_eq({tag, "_addr"},  mem_addr, exp_addr);
      check_eq({tag, "_full"},  full, exp_full);
      check_eq({tag, "_err"},   err_illegal, exp_err);
      check_eq({tag, "_ready"}, req_ready, exp_ready);
`ifdef ENCODER_CHECKSUM_EN
      check_eq({tag, "_chk"},   checksum, exp_chk);
`endif
   endtask

   task automatic drive_req(input req_t r);
      req_fmt    = 2'(r.fmt);
      req_opcode = 6'(r.opcode);
      req_funct  = 6'(r.funct);
      req_rs     = 5'(r.rs);
      req_rt     = 5'(r.rt);
      req_rd     = 5'(r.rd);
      req_shamt  = 5'(r.shamt);
      req_imm    = 16'(r.imm);
      req_target = 26'(r.target);
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_count = 0; exp_addr = 0; exp_err = 0; exp_full = 0; exp_ready = 1; exp_chk = 32'h0;
      check_state(tag);
   endtask

   task automatic send(input string tag, input req_t r, input int ack_delay);
      logic [31:0] w;
      bit ok;
      model_enc(r, w, ok);
      drive_req(r);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      if (!exp_ready) begin
         check_state({tag, "_ignored"});
      end else if (!ok) begin
         exp_err = 1;
         check_state({tag, "_illegal"});
      end else begin
         check_eq({tag, "_we"},    mem_we, 1);
         check_eq({tag, "_data"},  mem_wdata, w);
         check_eq({tag, "_addr"},  mem_addr, exp_addr);
         check_eq({tag, "_ready"}, req_ready, 0);
         for (int i = 0; i < ack_delay; i++) begin
            tick();
            check_eq({tag, "_hold_we"},    mem_we, 1);
            check_eq({tag, "_hold_data"},  mem_wdata, w);
            check_eq({tag, "_hold_addr"},  mem_addr, exp_addr);
            check_eq({tag, "_hold_ready"}, req_ready, 0);
         end
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
         exp_count++;
         exp_addr = (exp_addr + 1) % (1 << AW);
         exp_chk  = exp_chk ^ w;
         if (exp_count == MW) begin
            exp_full  = 1;
            exp_ready = 0;
         end
         check_state({tag, "_ack"});
      end
   endtask

   function automatic req_t mk(input int fmt, input int op, input int fn, input int rs,
                               input int rt, input int rd, input int sh, input int imm,
                               input int tgt);
      req_t r;
      r.fmt = fmt; r.opcode = op; r.funct = fn; r.rs = rs; r.rt = rt; r.rd = rd;
      r.shamt = sh; r.imm = imm; r.target = tgt;
      return r;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      int i_ops[6];
      int fns[3];
      i_ops = '{8, 12, 35, 43, 4, 5};
      fns   = '{0, 32, 37};
      r.fmt    = $urandom_range(0, 3);
      r.rs     = $urandom_range(0, 31);
      r.rt     = $urandom_range(0, 31);
      r.rd     = $urandom_range(0, 31);
      r.imm    = $urandom_range(0, 65535);
      r.target = $urandom_range(0, 67108863);
      r.opcode = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0)
         r.opcode = (r.fmt == 2) ? $urandom_range(2, 3) : i_ops[$urandom_range(0, 5)];
      r.funct = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 2)] : $urandom_range(0, 63);
      r.shamt = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(0, 31);
      return r;
   endfunction

   initial begin
      reset = 1'b0; start = 1'b0; req_valid = 1'b0; mem_ack = 1'b0;
      drive_req(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_count = 0; exp_addr = 0; exp_err = 0; exp_full = 0; exp_ready = 0; exp_chk = 32'h0;
      #2;
      check_state("reset");
      check_eq("reset_wdata", mem_wdata, 32'h0);
      #10 reset = 1'b1;
      tick();
      send("idle_req", mk(0, 0, 32, 1, 2, 3, 0, 0, 0), 0);

      // Plan 1-3: directed encodings, ack backpressure, illegal drop.
      do_start("tp1_start");
      send("tp1_add", mk(0, 0, 32, 1, 2, 3, 0, 0, 0), 0);
      check_eq("tp1_word", mem_wdata, 32'h00221820);
      send("tp2_addi", mk(1, 8, 0, 0, 8, 0, 0, 5, 0), 0);
`ifdef ENCODER_CHECKSUM_EN
      check_eq("tp6_checksum", checksum, 32'h202A1825);
`endif
      do_start("tp2_restart");
      send("tp2_sw", mk(1, 43, 0, 29, 31, 0, 0, 4, 0), 3);
      check_eq("tp2_word", mem_wdata, 32'hAFBF0004);
      send("tp3_j", mk(2, 2, 0, 0, 0, 0, 0, 0, 32'h0100000), 1);
      check_eq("tp3_word", mem_wdata, 32'h08100000);
      send("tp3_bad_funct", mk(0, 0, 34, 1, 2, 3, 0, 0, 0), 0);
      send("tp3_bad_shamt", mk(0, 0, 32, 1, 2, 3, 4, 0, 0), 0);
      send("tp3_fmt3", mk(3, 8, 0, 1, 2, 3, 0, 0, 0), 0);
      send("tp3_sll", mk(0, 0, 0, 0, 2, 3, 7, 0, 0), 2);

      // Plan 4: fills to MAX_WORDS; further requests are ignored.
      send("tp4_fill", mk(1, 35, 0, 4, 5, 0, 0, 16'hFFFC, 0), 0);
      check_eq("tp4_full", full, 1);
      send("tp4_extra", mk(1, 8, 0, 1, 1, 0, 0, 1, 0), 0);
      do_start("tp4_restart");

      // Plan 5: start abandons a pending write; reset clears asynchronously.
      send("tp5_bad", mk(2, 9, 0, 0, 0, 0, 0, 0, 5), 0);
      drive_req(mk(2, 3, 0, 0, 0, 0, 0, 0, 123));
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check_eq("tp5_we_pending", mem_we, 1);
      do_start("tp5_start_abort");
      drive_req(mk(1, 12, 0, 3, 4, 0, 0, 255, 0));
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      exp_count = 0; exp_addr = 0; exp_err = 0; exp_full = 0; exp_ready = 0; exp_chk = 32'h0;
      check_state("tp5_reset");
      check_eq("tp5_reset_wdata", mem_wdata, 32'h0);
      #3 reset = 1'b1;
      tick();

      // Random traffic against the reference model.
      do_start("rnd_start");
      for (int k = 0; k < 300; k++) begin
         if (exp_full || $urandom_range(0, 24) == 0)
            do_start("rnd_restart");
         send("rnd", rand_req(), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the decode stage: builds 32-bit MIPS instruction words from field requests and writes them sequentially into instruction memory.
- Used by the boot/test loader to fill program memory before the core runs.
- Supported ops: R (sll, add, or), I (addi, andi, lw, sw, beq, bne), J (j, jal).
- Illegal requests are rejected and flagged, never written.

Parameters:
- ADDR_WIDTH, 8, width of mem_addr (word address).
- BASE_ADDR, 0, first word address written after start.
- MAX_WORDS, 256, words accepted before the block reports full; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse: begin a new load at BASE_ADDR, clear count and errors.
- req_valid  in  1  request present.
- req_ready  out  1  encoder accepts a request this cycle.
- req_fmt  in  2  0 = R, 1 = I, 2 = J, 3 = illegal.
- req_opcode  in  6  opcode (I/J); ignored for R.
- req_funct  in  6  funct (R only).
- req_rs, req_rt, req_rd, req_shamt  in  5 each  register and shift fields.
- req_imm  in  16  immediate (I).
- req_target  in  26  jump target (J).
- mem_we  out  1  write strobe, held until mem_ack.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  32  encoded word.
- mem_ack  in  1  memory accepted the write this cycle.
- word_count  out  ADDR_WIDTH+1  words written since start.
- full  out  1  MAX_WORDS written.
- err_illegal  out  1  sticky; set on a rejected request, cleared by start.

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE; req_ready = 0; mem_we = 0; mem_addr = BASE_ADDR; mem_wdata = 0.
  - word_count = 0; full = 0; err_illegal = 0.
- FSM states: IDLE, ACCEPT, WRITE, FULL. All outputs are registered.
- start has priority in every state:
  - Next cycle: state = ACCEPT, mem_addr = BASE_ADDR, word_count = 0, full = 0, err_illegal = 0, mem_we = 0.
  - A write in progress is abandoned. A request presented in the start cycle is not accepted.
- ACCEPT:
  - req_ready = 1. A transfer occurs when req_valid and req_ready are both 1.
  - Legal request: encode, latch into mem_wdata, go to WRITE. mem_we = 1 on the following cycle (latency 1).
  - Illegal request: set err_illegal, drop the request, stay in ACCEPT.
- WRITE:
  - req_ready = 0; mem_we = 1; mem_addr and mem_wdata held stable until mem_ack.
  - On mem_ack: mem_we = 0, mem_addr += 1, word_count += 1.
  - Then go to FULL if the new word_count == MAX_WORDS, else ACCEPT.
  - Peak rate: one word per 2 cycles.
- FULL: req_ready = 0, full = 1; leaves only on start.
- Encoding:
  - R: {6'h00, rs, rt, rd, shamt, funct}.
  - I: {opcode, rs, rt, imm}.
  - J: {opcode, target}.
- Legality:
  - R: funct ∈ {0x00, 0x20, 0x25}; shamt must be 0 unless funct = 0x00.
  - I: opcode ∈ {0x08, 0x0C, 0x23, 0x2B, 0x04, 0x05}.
  - J: opcode ∈ {0x02, 0x03}.
  - req_fmt = 3 is always illegal.
- mem_addr wraps modulo 2**ADDR_WIDTH; unreachable when MAX_WORDS ≤ depth.

Optional Feature:
- Macro: ENCODER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0] = XOR of all words acknowledged since start.
  - Reset value 0; cleared by start; updated on the mem_ack cycle.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package mips_isa_pkg holds:
  - Opcode constants: OP_RTYPE, OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL.
  - Funct constants: FN_SLL, FN_ADD, FN_OR.
  - The req_fmt encoding.
- The same package is shared with the decode stage.
- Sub-module mips_field_packer: purely combinational; produces the encoded word and a legal flag from the request fields.
- The FSM, address counter and handshake stay in the top module.

Test Plan:
1. Reset then start; R add rs=1, rt=2, rd=3 → mem_wdata 0x00221820 at addr 0, mem_we one cycle after accept, word_count 1 after mem_ack.
2. I addi rs=0, rt=8, imm=5, then I sw rs=29, rt=31, imm=4 → 0x20080005 @0 and 0xAFBF0004 @1; mem_ack held low 3 cycles → addr/data stable, req_ready = 0 throughout.
3. J opcode 0x02, target 0x0100000 → 0x08100000; then R funct 0x22 → err_illegal = 1, no mem_we, word_count unchanged, req_ready stays 1.
4. MAX_WORDS = 4: write 4 legal words → full = 1, req_ready = 0, 5th request ignored; start → full = 0, mem_addr = BASE_ADDR.
5. start asserted during WRITE before mem_ack → mem_we low next cycle, word_count 0, err_illegal cleared; reset asserted mid-WRITE → all outputs at reset values immediately.
6. With ENCODER_CHECKSUM_EN: words 0x00221820 and 0x20080005 → checksum 0x202A1825.
